// File: rtl/spram_1rw.sv
// Single-port 1RW RAM with a registered read port (one-cycle latency).
// rdata holds its last read value whenever no read is performed.
module spram_1rw #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned ADDR_WIDTH = $clog2(FIFO_DEPTH)
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] r_rdata;

  // Contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        r_mem[addr] <= wdata;
      end else begin
        r_rdata <= r_mem[addr];
      end
    end
  end

  assign rdata = r_rdata;

endmodule

// File: rtl/spram_bank_fifo.sv
// One FIFO bank on a single-port RAM with a one-entry registered output stage.
// Reads take priority over writes so the RAM port is never contended.
module spram_bank_fifo #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned ADDR_WIDTH = $clog2(FIFO_DEPTH),
  parameter int unsigned CNT_WIDTH  = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready
);

  localparam logic [ADDR_WIDTH-1:0] LastPtr = ADDR_WIDTH'(FIFO_DEPTH - 1);
  localparam logic [CNT_WIDTH-1:0]  FullCnt = CNT_WIDTH'(FIFO_DEPTH);

  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [CNT_WIDTH-1:0]  r_ram_cnt;
  logic                  r_rd_pend;
  logic                  r_out_valid;
  logic [DATA_WIDTH-1:0] r_out_data;

  logic                  w_rd_issue;
  logic                  w_wr_xfer;
  logic                  w_pop;
  logic                  w_ram_en;
  logic                  w_ram_we;
  logic [ADDR_WIDTH-1:0] w_ram_addr;
  logic [DATA_WIDTH-1:0] w_ram_rdata;

  // A read may only issue when its data has somewhere to land next cycle.
  always_comb begin
    w_rd_issue = (r_ram_cnt != '0) & ~r_rd_pend & (~r_out_valid | out_ready);
    in_ready   = (r_ram_cnt != FullCnt) & ~w_rd_issue;
    w_wr_xfer  = in_valid & in_ready;
    w_pop      = r_out_valid & out_ready;
    w_ram_en   = w_rd_issue | w_wr_xfer;
    w_ram_we   = w_wr_xfer;
    w_ram_addr = w_rd_issue ? r_rd_ptr : r_wr_ptr;
  end

  spram_1rw #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk   (clk),
    .en    (w_ram_en),
    .we    (w_ram_we),
    .addr  (w_ram_addr),
    .wdata (in_data),
    .rdata (w_ram_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_ram_cnt   <= '0;
      r_rd_pend   <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else begin
      if (w_wr_xfer) begin
        r_wr_ptr  <= (r_wr_ptr == LastPtr) ? '0 : r_wr_ptr + 1'b1;
        r_ram_cnt <= r_ram_cnt + 1'b1;
      end else if (w_rd_issue) begin
        r_rd_ptr  <= (r_rd_ptr == LastPtr) ? '0 : r_rd_ptr + 1'b1;
        r_ram_cnt <= r_ram_cnt - 1'b1;
      end
      r_rd_pend <= w_rd_issue;
      // A landing read refills the output stage in the same edge as a pop.
      if (r_rd_pend) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_ram_rdata;
      end else if (w_pop) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;

endmodule

// File: tb/tb_spram_bank_fifo.sv
// Randomised scoreboard bench for spram_bank_fifo: a depth-16 and a depth-5 instance.
module tb_spram_bank_fifo;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [7:0] a_in_data = '0, a_out_data;
  logic a_in_valid = 1'b0, a_in_ready, a_out_valid, a_out_ready = 1'b0;
  logic [7:0] b_in_data = '0, b_out_data;
  logic b_in_valid = 1'b0, b_in_ready, b_out_valid, b_out_ready = 1'b0;

  spram_bank_fifo #(.DATA_WIDTH(8), .FIFO_DEPTH(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_data(a_in_data), .in_valid(a_in_valid),
    .in_ready(a_in_ready), .out_data(a_out_data), .out_valid(a_out_valid),
    .out_ready(a_out_ready)
  );

  spram_bank_fifo #(.DATA_WIDTH(8), .FIFO_DEPTH(5)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_data(b_in_data), .in_valid(b_in_valid),
    .in_ready(b_in_ready), .out_data(b_out_data), .out_valid(b_out_valid),
    .out_ready(b_out_ready)
  );

  int n_checks = 0;
  int n_fail = 0;
  logic [7:0] q_a[$];
  logic [7:0] q_b[$];
  logic a_hold_v = 1'b0, b_hold_v = 1'b0;
  logic [7:0] a_hold_d = '0, b_hold_d = '0;
  logic [7:0] exp_d;
  int b_pops = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Monitor: record accepted words, compare every pop against the queue head.
  always @(negedge clk) begin
    #2;
    if (rst_n) begin
      if (a_in_valid && a_in_ready) q_a.push_back(a_in_data);
      if (a_hold_v) begin
        check("a_hold_valid", 32'(a_out_valid), 32'd1);
        check("a_hold_data", 32'(a_out_data), 32'(a_hold_d));
      end
      if (a_out_valid && a_out_ready) begin
        if (q_a.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL a_pop_empty: got pop of %0h, expected no word", a_out_data);
        end else begin
          exp_d = q_a.pop_front();
          check("a_data", 32'(a_out_data), 32'(exp_d));
        end
      end
      a_hold_v = a_out_valid && !a_out_ready;
      a_hold_d = a_out_data;

      if (b_in_valid && b_in_ready) q_b.push_back(b_in_data);
      if (b_hold_v) begin
        check("b_hold_valid", 32'(b_out_valid), 32'd1);
        check("b_hold_data", 32'(b_out_data), 32'(b_hold_d));
      end
      if (b_out_valid && b_out_ready) begin
        b_pops++;
        if (q_b.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL b_pop_empty: got pop of %0h, expected no word", b_out_data);
        end else begin
          exp_d = q_b.pop_front();
          check("b_data", 32'(b_out_data), 32'(exp_d));
        end
      end
      b_hold_v = b_out_valid && !b_out_ready;
      b_hold_d = b_out_data;
      check("b_ram_cnt_range", 32'(dut_b.r_ram_cnt <= 3'd5), 32'd1);
    end
  end

  task automatic step_a(input logic v, input logic [7:0] d, input logic r, output logic acc);
    @(negedge clk);
    a_in_valid = v; a_in_data = d; a_out_ready = r;
    #1;
    acc = v & a_in_ready;
  endtask

  task automatic step_b(input logic v, input logic [7:0] d, input logic r, output logic acc);
    @(negedge clk);
    b_in_valid = v; b_in_data = d; b_out_ready = r;
    #1;
    acc = v & b_in_ready;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic acc;
    int idx, last, npop, cnt, cyc;
    bit found;

    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    check("rst_a_out_valid", 32'(a_out_valid), 32'd0);
    check("rst_a_out_data", 32'(a_out_data), 32'd0);
    check("rst_b_out_valid", 32'(b_out_valid), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    step_a(1'b0, 8'h00, 1'b0, acc);
    check("rst_a_in_ready", 32'(a_in_ready), 32'd1);
    check("rst_b_in_ready", 32'(b_in_ready), 32'd1);

    // Fill: 16 RAM entries plus the output register.
    idx = 0;
    for (int c = 0; c < 40; c++) begin
      step_a(idx <= 20, 8'(idx), 1'b0, acc);
      if (acc) idx++;
    end
    check("fill_count", 32'(idx), 32'd17);
    check("fill_in_ready", 32'(a_in_ready), 32'd0);
    check("fill_out_valid", 32'(a_out_valid), 32'd1);
    check("fill_out_data", 32'(a_out_data), 32'd0);

    // Drain: one pop every two cycles, then empty.
    last = -1; npop = 0;
    for (int c = 0; c < 60; c++) begin
      step_a(1'b0, 8'h00, 1'b1, acc);
      if (a_out_valid) begin
        if (last >= 0) check("drain_gap", 32'(c - last), 32'd2);
        last = c;
        npop++;
      end
    end
    check("drain_count", 32'(npop), 32'd17);
    check("drain_out_valid", 32'(a_out_valid), 32'd0);
    check("drain_queue_empty", 32'(q_a.size()), 32'd0);

    // Latency: accepted at edge N, visible after edge N+2.
    step_a(1'b1, 8'hA5, 1'b0, acc);
    check("lat_accept", 32'(acc), 32'd1);
    step_a(1'b0, 8'h00, 1'b0, acc);
    check("lat_after_n", 32'(a_out_valid), 32'd0);
    step_a(1'b0, 8'h00, 1'b0, acc);
    check("lat_after_n1", 32'(a_out_valid), 32'd0);
    step_a(1'b0, 8'h00, 1'b0, acc);
    check("lat_after_n2_valid", 32'(a_out_valid), 32'd1);
    check("lat_after_n2_data", 32'(a_out_data), 32'hA5);
    step_a(1'b0, 8'h00, 1'b1, acc);
    step_a(1'b0, 8'h00, 1'b0, acc);

    // Stream with ~30% consumer backpressure.
    cnt = 0; cyc = 0;
    while (cnt < 200 && cyc < 3000) begin
      step_a(1'b1, 8'($urandom), $urandom_range(0, 99) >= 30, acc);
      if (acc) cnt++;
      cyc++;
    end
    cyc = 0;
    while ((q_a.size() != 0 || a_out_valid) && cyc < 200) begin
      step_a(1'b0, 8'h00, 1'b1, acc);
      cyc++;
    end
    step_a(1'b0, 8'h00, 1'b0, acc);
    check("stream_count", 32'(cnt), 32'd200);
    check("stream_queue_empty", 32'(q_a.size()), 32'd0);
    check("stream_out_valid", 32'(a_out_valid), 32'd0);

    // Wrap on the depth-5 bank with random valid/ready.
    b_pops = 0; cnt = 0; cyc = 0;
    while (cnt < 40 && cyc < 1000) begin
      step_b($urandom_range(0, 99) < 60, 8'($urandom), $urandom_range(0, 99) < 60, acc);
      if (acc) cnt++;
      cyc++;
    end
    cyc = 0;
    while ((q_b.size() != 0 || b_out_valid) && cyc < 100) begin
      step_b(1'b0, 8'h00, 1'b1, acc);
      cyc++;
    end
    step_b(1'b0, 8'h00, 1'b0, acc);
    check("wrap_count", 32'(cnt), 32'd40);
    check("wrap_pops", 32'(b_pops), 32'd40);
    check("wrap_queue_empty", 32'(q_b.size()), 32'd0);

    // Reset mid-stream with a read in flight.
    cnt = 0; cyc = 0;
    while (cnt < 6 && cyc < 40) begin
      step_a(1'b1, 8'(8'h60 + cnt), 1'b0, acc);
      if (acc) cnt++;
      cyc++;
    end
    step_a(1'b0, 8'h00, 1'b0, acc);
    step_a(1'b0, 8'h00, 1'b1, acc);
    check("rst_mid_pop_pre", 32'(a_out_valid), 32'd1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_async_out_valid", 32'(a_out_valid), 32'd0);
    q_a.delete();
    a_hold_v = 1'b0;
    #1 rst_n = 1'b1;
    step_a(1'b0, 8'h00, 1'b0, acc);
    check("rst_mid_in_ready", 32'(a_in_ready), 32'd1);
    check("rst_mid_out_valid", 32'(a_out_valid), 32'd0);
    step_a(1'b1, 8'h3C, 1'b0, acc);
    check("rst_mid_accept", 32'(acc), 32'd1);
    found = 1'b0;
    for (int c = 0; c < 10 && !found; c++) begin
      step_a(1'b0, 8'h00, 1'b0, acc);
      if (a_out_valid) found = 1'b1;
    end
    check("rst_mid_out_seen", 32'(found), 32'd1);
    check("rst_mid_out_data", 32'(a_out_data), 32'h3C);
    step_a(1'b0, 8'h00, 1'b1, acc);
    step_a(1'b0, 8'h00, 1'b0, acc);
    check("rst_mid_queue_empty", 32'(q_a.size()), 32'd0);
    check("rst_mid_final_valid", 32'(a_out_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/spram_bank_fifo.md
Name: spram_bank_fifo

Overview:
- Single-bank FIFO built on one single-port (1RW) RAM. Each cycle the RAM does exactly one read or one write, never both.
- A one-entry output register gives registered valid/ready outputs.
- This block is the per-bank responder that the ping-pong two-bank FIFO controller drives. Two instances alternate so the pair sustains one transfer per cycle, while each bank sustains at most one transfer per two cycles when streaming.

Parameters:
- DATA_WIDTH, 8, width of each data word.
- FIFO_DEPTH, 16, number of RAM entries. Must be >= 2. Need not be a power of two.
- ADDR_WIDTH, $clog2(FIFO_DEPTH), RAM address and pointer width.
- CNT_WIDTH, $clog2(FIFO_DEPTH+1), width of the RAM occupancy counter.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_data  in  DATA_WIDTH  write data.
- in_valid  in  1  write request.
- in_ready  out  1  bank can accept a word this cycle. Combinational.
- out_data  out  DATA_WIDTH  head-of-FIFO data. Registered.
- out_valid  out  1  out_data holds a valid word. Registered.
- out_ready  in  1  consumer accepts out_data.

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous and active-low. All state clears on rst_n low, regardless of clock.
- Reset values:
  - out_valid=0, out_data=0.
  - wr_ptr=0, rd_ptr=0, ram_cnt=0, rd_pend=0.
  - in_ready = 1 once reset deasserts.
- Handshakes:
  - Write transfer when in_valid & in_ready.
  - Pop when out_valid & out_ready.
  - out_valid and out_data stay stable while out_valid=1 and out_ready=0.
- Read issue (combinational): rd_issue = (ram_cnt != 0) & ~rd_pend & (~out_valid | out_ready).
- Write path:
  - in_ready = (ram_cnt != FIFO_DEPTH) & ~rd_issue.
  - Read has priority over write, so the RAM port is never contended.
  - in_ready depends combinationally on out_ready. The consumer must not derive out_ready from in_ready.
- RAM access, one per cycle:
  - If rd_issue: RAM read at rd_ptr.
  - Else if write transfer: RAM write at wr_ptr.
  - Else: RAM idle (enable low).
- Pointers: each pointer increments by one on its own operation and wraps from FIFO_DEPTH-1 to 0. They are not binary-modulo.
- ram_cnt:
  - +1 on write transfer, -1 on rd_issue. The two are mutually exclusive.
  - ram_cnt never exceeds FIFO_DEPTH and never underflows.
- Read latency:
  - RAM data is valid one cycle after issue.
  - rd_pend <= rd_issue.
  - When rd_pend=1: out_data <= ram_dout and out_valid <= 1. The issue condition guarantees the output register is empty or popped in that same cycle.
  - When rd_pend=0 and a pop occurs: out_valid <= 0.
- Capacity: FIFO_DEPTH + 1 words (RAM plus output register). An in-flight read always has a free destination.
- Latency: a word accepted at edge N into an empty bank gives out_valid=1 after edge N+2.
- Throughput: a continuous stream alternates read/write, giving 1 word per 2 cycles per bank.
- Boundary cases:
  - Full (ram_cnt==FIFO_DEPTH): in_ready=0. The write is held off without data loss.
  - Empty: no read issues. out_valid remains 0 after the last pop.
  - Simultaneous pop and rd_pend: the output register reloads in the same edge with no bubble in out_valid.
  - Reset mid-stream: all contents are discarded, including in-flight reads. out_valid drops immediately (asynchronously).
- RAM contents are not reset. The RAM is never read before it has been written.

Decomposition:
- No shared package is needed; all widths derive from the parameters.
- One sub-module: spram_1rw (parameters DATA_WIDTH, FIFO_DEPTH, ADDR_WIDTH).
  - Ports: clk, en, we, addr, wdata, rdata.
  - Registered read, 1-cycle latency. rdata holds its value when en=0.
- Pointer, counter and output-stage logic live in spram_bank_fifo.

Test Plan:
- Fill: FIFO_DEPTH=16, out_ready=0, in_valid=1 with data 0..20 -> exactly 17 words accepted (0..16). in_ready stays 0 afterwards. out_valid=1 with out_data=0.
- Drain: after fill, out_ready=1, in_valid=0 -> words 0..16 emerge in order, one pop every 2 cycles. After 16 the bank is empty and out_valid=0.
- Latency: empty bank, single write of 0xA5 at edge N -> out_valid rises after edge N+2 with out_data=0xA5.
- Stream and backpressure: in_valid=1 and out_ready=1 continuously, with out_ready randomly low 30% of cycles, for 200 words -> in-order, lossless output. out_data is stable whenever out_valid=1 and out_ready=0.
- Wrap: FIFO_DEPTH=5 instance, 40 words with random valid/ready -> correct order across pointer wrap 4->0. ram_cnt stays within 0..5.
- Reset mid-operation: 6 words queued with a read pending, rst_n pulsed low mid-cycle -> out_valid=0 immediately. After release the bank is empty (in_ready=1), and the next word written is the next word read.
